// File: rtl/regfile.sv
// regfile: 32 x DATA_WIDTH RISC-V integer register file.
// Two registered read ports and one write port. x0 is hardwired to zero.
// Compile-time option REGFILE_BYPASS_EN: when defined, a read that hits the
// register being written on the same edge returns the new data
// (write-first). When undefined, it returns the old contents (read-first).
// Reset is synchronous and active-high. It clears all registers and both
// read ports.
module regfile #(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [4:0]            read_reg1,
    input  logic [4:0]            read_reg2,
    input  logic [4:0]            write_reg,
    input  logic [DATA_WIDTH-1:0] write_data,
    input  logic                  write,
    output logic [DATA_WIDTH-1:0] read_data1,
    output logic [DATA_WIDTH-1:0] read_data2
);

    logic [DATA_WIDTH-1:0] regs_r [32];
    logic [DATA_WIDTH-1:0] rd1_s;
    logic [DATA_WIDTH-1:0] rd2_s;
    logic                  wr_en_s;

    // Qualified write strobe: x0 writes are dropped here so nothing downstream sees them.
    always_comb begin
        wr_en_s = 1'b0;
        if (write && (write_reg != 5'd0)) begin
            wr_en_s = 1'b1;
        end else begin
            wr_en_s = 1'b0;
        end
    end

    // Port 1 read mux: x0 forced to zero, with optional same-edge forwarding of write_data.
    always_comb begin
        rd1_s = {DATA_WIDTH{1'b0}};
        if (read_reg1 == 5'd0) begin
            rd1_s = {DATA_WIDTH{1'b0}};
`ifdef REGFILE_BYPASS_EN
        end else if (wr_en_s && (write_reg == read_reg1)) begin
            rd1_s = write_data;
`endif
        end else begin
            rd1_s = regs_r[read_reg1];
        end
    end

    // Port 2 read mux: same selection rules as port 1.
    always_comb begin
        rd2_s = {DATA_WIDTH{1'b0}};
        if (read_reg2 == 5'd0) begin
            rd2_s = {DATA_WIDTH{1'b0}};
`ifdef REGFILE_BYPASS_EN
        end else if (wr_en_s && (write_reg == read_reg2)) begin
            rd2_s = write_data;
`endif
        end else begin
            rd2_s = regs_r[read_reg2];
        end
    end

    // Register storage: reset clears everything and takes priority over any pending write.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 32; i++) begin
                regs_r[i] <= {DATA_WIDTH{1'b0}};
            end
        end else if (wr_en_s) begin
            regs_r[write_reg] <= write_data;
        end else begin
            regs_r[write_reg] <= regs_r[write_reg];
        end
    end

    // Output registers: the one-cycle read latency, cleared by reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            read_data1 <= {DATA_WIDTH{1'b0}};
            read_data2 <= {DATA_WIDTH{1'b0}};
        end else begin
            read_data1 <= rd1_s;
            read_data2 <= rd2_s;
        end
    end

endmodule

// File: doc/regfile.md
# regfile

Two-read, one-write RISC-V integer register file that supplies `op1` and `op2` operands to the ALU and accepts the writeback result. It holds 32 general-purpose registers; `x0` is hardwired to zero. Both read ports are registered, giving one cycle of latency. Writes commit on the clock edge. An optional write-to-read bypass is selected at compile time.

## Interface
Parameters:
- `DATA_WIDTH`, default 32: register and data-port width.

Ports:
- `clk` input 1: the single clock; all state updates on the rising edge.
- `rst` input 1: synchronous, active-high reset.
- `read_reg1` input 5: register index for read port 1.
- `read_reg2` input 5: register index for read port 2.
- `write_reg` input 5: register index for the write port.
- `write_data` input DATA_WIDTH: data to be written.
- `write` input 1: write enable.
- `read_data1` output DATA_WIDTH: registered data for port 1; feeds ALU `op1`.
- `read_data2` output DATA_WIDTH: registered data for port 2; feeds the ALU `op2` path.

## Operation
- Storage: 32 × DATA_WIDTH registers, `x0`–`x31`.
- Write:
  - At a rising edge with `write`=1, `rst`=0 and `write_reg`≠0, `x[write_reg]` ← `write_data`.
  - Writes with `write_reg`=0 are discarded. `x0` always reads 0.
- Read:
  - At every rising edge with `rst`=0, `read_data1` ← value of `x[read_reg1]`, and `read_data2` ← value of `x[read_reg2]`.
  - Reads occur every cycle; there is no read enable.
  - Both ports may address the same register in the same cycle, and both return the same value.
- Reset:
  - While `rst`=1 at a rising edge, all 32 registers and both outputs clear to 0.
  - `rst` overrides `write`: a write presented during reset is lost.
  - Reset asserted mid-sequence discards any in-flight write. The first read after reset deasserts returns 0 for every index.
- Same-edge conflict (read index equals `write_reg`, `write`=1, index≠0): the result is defined under Configuration.
- `x0` with `write`=1 and `write_reg`=0: the read of `x0` on that same edge returns 0, in both configurations.

## Timing
- Read latency is 1 cycle. An address applied in cycle N produces data on `read_data*` from the edge ending cycle N. That data is stable for all of cycle N+1.
- Write latency is 1 edge. Data written at edge E is visible to a read sampled at edge E+1 in all configurations.
- Outputs change only on `clk` rising edges. There is no combinational path from any input to `read_data*`.
- Reset values: `read_data1`=0, `read_data2`=0, all registers 0.
- No handshake: one write and two reads may occur every cycle, back to back, indefinitely.

## Configuration
- Macro: `REGFILE_BYPASS_EN`.
- Defined: on a same-edge conflict, the affected read port captures `write_data` (write-first). This lets a writeback and a dependent operand read share a cycle.
- Undefined: on a same-edge conflict, the affected read port captures the pre-write register value (read-first). The new value appears on the following read.
- Neither setting changes reset behaviour, `x0` behaviour or latency.

## Test plan
- Reset clears state:
  - Write 0xDEADBEEF to x5, then assert `rst` for 1 cycle.
  - Read x5 on both ports.
  - Required: 0x00000000 on both ports, including the cycle immediately after reset. Outputs are also 0 while `rst`=1.
- Basic write/read:
  - Write 0x12345678 to x1 and 0xFFFFFFFF to x31, then read x1 on port 1 and x31 on port 2.
  - Required: 0x12345678 on port 1 and 0xFFFFFFFF on port 2, both one edge after the address is applied.
- x0 immutability:
  - Write 0xA5A5A5A5 to x0, then read x0 on both ports.
  - Required: 0 on both ports, on the same edge and on later edges.
- Same-edge conflict:
  - x7 holds 0x00000011; write 0x00000022 to x7 while reading x7 on both ports.
  - Required with `REGFILE_BYPASS_EN`: 0x00000022 on that edge.
  - Required without it: 0x00000011 on that edge, then 0x00000022 on the next edge.
- Reset priority:
  - Assert `rst` and `write`=1 together, writing 0x0BADF00D to x3. Deassert `rst`, then read x3.
  - Required: 0.
- Back-to-back stress:
  - For 1000 cycles, apply random writes and reads across all indices, compared against a reference model.
  - Required: every read matches the model for the configured mode; x0 always reads 0.
